// File: rtl/vector_lane_fu_sequencer.sv
// ============================================================================
// Module      : vector_lane_fu_sequencer
// Description : Per-lane sequencer that issues one element op at a time to the
//               arithmetic, multiply or divide unit, waits for completion (with
//               a hang timeout) and holds the result until downstream takes it.
//               Optional build macro VLANE_SEQ_ARITH_BYPASS_EN: arithmetic ops
//               start and complete in the acceptance cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vector_lane_fu_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [2:0]  fu_sel,
  output logic        start,
  output logic        start_mu,
  output logic        start_div,
  input  logic        busy_a,
  input  logic        busy_mu,
  input  logic        busy_du,
  input  logic [31:0] wdata_a,
  input  logic [31:0] wdata_mu,
  input  logic [31:0] wdata_du,
  input  logic        exception_a,
  input  logic        exception_mu,
  input  logic        exception_du,
  input  logic        stall_e_m,
  output logic [31:0] lane_result,
  output logic        result_valid,
  output logic        busy,
  output logic        exception
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [2:0]       c_FU_ARITH = 3'd0;
  localparam logic [2:0]       c_FU_MUL   = 3'd1;
  localparam logic [2:0]       c_FU_DIV   = 3'd2;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_fu;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_result;
  logic              r_exc;

  logic              w_accept;
  logic              w_fu_legal;
  logic              w_sel_busy;
  logic [31:0]       w_sel_wdata;
  logic              w_sel_exc;
  logic              w_timeout;

  logic              w_start_a;
  logic              w_start_mu;
  logic              w_start_du;
  logic              w_cap_unit;
  logic              w_cap_bypass;
  logic              w_fault;
  logic              w_cnt_clr;
  logic              w_cnt_inc;

  assign w_accept   = issue_valid && (r_state == S_IDLE);
  assign w_fu_legal = (fu_sel <= c_FU_DIV);
  assign w_timeout  = (r_cnt == c_CNT_LAST);

  // Only the latched unit's handshake is observed; the others are don't-care.
  always_comb begin
    w_sel_busy  = 1'b0;
    w_sel_wdata = 32'd0;
    w_sel_exc   = 1'b0;
    case (r_fu)
      c_FU_ARITH: begin
        w_sel_busy  = busy_a;
        w_sel_wdata = wdata_a;
        w_sel_exc   = exception_a;
      end
      c_FU_MUL: begin
        w_sel_busy  = busy_mu;
        w_sel_wdata = wdata_mu;
        w_sel_exc   = exception_mu;
      end
      c_FU_DIV: begin
        w_sel_busy  = busy_du;
        w_sel_wdata = wdata_du;
        w_sel_exc   = exception_du;
      end
      default: begin
        w_sel_busy  = 1'b0;
        w_sel_wdata = 32'd0;
        w_sel_exc   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start_a    = 1'b0;
    w_start_mu   = 1'b0;
    w_start_du   = 1'b0;
    w_cap_unit   = 1'b0;
    w_cap_bypass = 1'b0;
    w_fault      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_fu_legal) begin
            w_fault      = 1'b1;
            w_next_state = S_DONE;
          end
`ifdef VLANE_SEQ_ARITH_BYPASS_EN
          else if (fu_sel == c_FU_ARITH) begin
            w_start_a    = 1'b1;
            w_cap_bypass = 1'b1;
            w_next_state = S_DONE;
          end
`endif
          else begin
            w_next_state = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        w_start_a    = (r_fu == c_FU_ARITH);
        w_start_mu   = (r_fu == c_FU_MUL);
        w_start_du   = (r_fu == c_FU_DIV);
        w_cnt_clr    = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the final timeout cycle still delivers the result.
        if (!w_sel_busy) begin
          w_cap_unit   = 1'b1;
          w_next_state = S_DONE;
        end else if (w_timeout) begin
          w_fault      = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_cnt_inc    = 1'b1;
        end
      end
      S_DONE: begin
        if (!stall_e_m) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fu     <= 3'd0;
      r_cnt    <= '0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fu <= fu_sel;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_fault) begin
        r_result <= 32'd0;
        r_exc    <= 1'b1;
      end else if (w_cap_unit) begin
        r_result <= w_sel_wdata;
        r_exc    <= w_sel_exc;
      end else if (w_cap_bypass) begin
        r_result <= wdata_a;
        r_exc    <= exception_a;
      end
    end
  end

  // Gating with nRST keeps the bypass start path quiet while reset is held.
  assign start        = w_start_a && nRST;
  assign start_mu     = w_start_mu && nRST;
  assign start_div    = w_start_du && nRST;
  assign issue_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign lane_result  = r_result;
  assign exception    = r_exc;

endmodule

`default_nettype wire

// File: doc/vector_lane_fu_sequencer.md
Name: vector_lane_fu_sequencer

Overview:
- Per-lane controller that sequences one element operation at a time onto the lane's function units: arithmetic, multiply and divide.
- Accepts an issue handshake from lane decode and generates a one-cycle start pulse to the selected unit. It then waits on that unit's busy, captures result and exception, and holds them until the execute/memory stage is not stalled.
- Drives the lane-level lane_result, busy and exception.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT-state cycles before a unit is declared hung. Legal range 2..255.
- CNT_W, 8: width of the timeout counter. Must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an op
- issue_ready  out  1  sequencer can accept an op
- fu_sel  in  3  target unit: 0 arith, 1 mul, 2 div; 3..7 illegal
- start  out  1  arithmetic-unit start pulse
- start_mu  out  1  multiply-unit start pulse
- start_div  out  1  divide-unit start pulse
- busy_a, busy_mu, busy_du  in  1 each  unit busy flags
- wdata_a, wdata_mu, wdata_du  in  32 each  unit results
- exception_a, exception_mu, exception_du  in  1 each  unit exceptions
- stall_e_m  in  1  downstream stall; result is consumed on a cycle with result_valid=1 and stall_e_m=0
- lane_result  out  32  captured result
- result_valid  out  1  lane_result is valid
- busy  out  1  sequencer occupied
- exception  out  1  captured exception, qualified by result_valid

Behaviour:
- Reset: nRST low asynchronously forces state IDLE, fu register 0, counter 0, lane_result 0, exception 0, all start pulses 0. This applies mid-operation too: any in-flight op is dropped and no result is produced. Units are not reset by this block.
- Only one op is in flight at a time. issue_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE:
  - When issue_valid && issue_ready at a rising edge, latch fu_sel.
  - Legal fu_sel: go to LAUNCH.
  - Illegal fu_sel: go to DONE with lane_result=0 and exception=1.
- LAUNCH (1 cycle): assert exactly one of start/start_mu/start_div, per the latched fu, for exactly this cycle. Clear the counter. Go to WAIT.
- WAIT:
  - Each cycle, sample the selected unit's busy.
  - busy=0: capture that unit's wdata into lane_result and its exception into exception, then go to DONE. Non-selected units' busy, wdata and exception are ignored.
  - busy=1: increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with busy still 1, go to DONE with lane_result=0 and exception=1.
- DONE:
  - result_valid=1. lane_result and exception are held stable.
  - stall_e_m=1: stay.
  - stall_e_m=0: go to IDLE. A new issue is accepted no earlier than the following cycle.
- result_valid=0 in all states other than DONE. The exception output is only meaningful while result_valid=1.
- Latency for a unit whose busy is already low at WAIT: accept at edge 0, LAUNCH in cycle 1, WAIT in cycle 2, result_valid in cycle 3. A unit that is busy for N WAIT cycles adds N cycles.
- Timeout precedence: if busy falls on the same cycle the counter reaches its limit, the result capture wins.
- stall_e_m has no effect outside DONE.
- No inputs are registered apart from the fu latch and the captures listed above.

Optional Feature:
- Macro: VLANE_SEQ_ARITH_BYPASS_EN.
- Defined:
  - An arithmetic op (fu_sel=0) accepted in IDLE drives start=1 combinationally in the acceptance cycle, and wdata_a/exception_a are captured at that same edge.
  - The FSM goes directly to DONE, so result_valid rises in cycle 1.
  - The mul/div path is unchanged.
- Undefined: arithmetic ops take the LAUNCH/WAIT path like every other unit, so result_valid rises in cycle 3.

Test Plan:
- Reset mid-WAIT (mul, busy_mu held 1): drop nRST → state IDLE, issue_ready=1, result_valid=0, lane_result=0 immediately, without waiting for a clock edge.
- Arith op, busy_a=0, wdata_a=32'h0000_0005, no stall → start high for exactly 1 cycle; result_valid=1 in cycle 3 with lane_result=5, exception=0; idle in cycle 4. With the macro defined, result_valid=1 in cycle 1.
- Mul op, busy_mu high for 4 WAIT cycles, wdata_mu=32'hFFFF_FFF0, stall_e_m=1 for 3 DONE cycles → start_mu pulses once; result held for 3 cycles at 32'hFFFF_FFF0, then released; issue_ready stays 0 throughout.
- Div op, exception_du=1 when busy_du falls → exception=1 alongside result_valid; no start or start_mu pulse ever seen.
- Div op, busy_du stuck at 1, TIMEOUT_CYCLES=8 → after 8 WAIT cycles, result_valid=1, exception=1, lane_result=0.
- fu_sel=5 → no start pulse; DONE on the next cycle with exception=1. issue_valid held high during a busy op is not accepted until IDLE.
